// File: rtl/addsub_multicycle.sv
// addsub_multicycle: slice-serial adder/subtractor with signed/unsigned
// set-less-than. Operands are consumed SLICE_W bits per clock with the
// inter-slice carry held in a register, so the combinational carry chain
// is only SLICE_W bits long. Valid/ready handshakes on both sides.
module addsub_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  // Reject slice widths that do not tile the operand exactly.
  generate
    if (SLICE_W < 1 || SLICE_W > WIDTH || (WIDTH % SLICE_W) != 0) begin : g_bad_params
      $error("addsub_multicycle: SLICE_W must divide WIDTH and be <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;

  int                 base;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W:0]   slice_sum;
  logic               msb_cin;
  logic               sub_like_in;

  logic               is_done;
  logic               slt_bit;
  logic               sltu_bit;
  logic [WIDTH-1:0]   final_result;

  assign sub_like_in = (i_op != OP_ADD);

  // Slice adder: current slice of A and (pre-inverted) B plus the carry register.
  always_comb begin
    base      = int'(idx_q) * SLICE_W;
    a_slice   = a_q[base +: SLICE_W];
    b_slice   = b_q[base +: SLICE_W];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry_q};
    // Carry into the top bit of the slice recovered from the bit-level sum.
    msb_cin   = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ slice_sum[SLICE_W-1];
  end

  // Next-state and datapath register updates for IDLE/CALC/DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b ^ {WIDTH{sub_like_in}};
          op_d    = i_op;
          carry_d = sub_like_in;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[base +: SLICE_W] = slice_sum[SLICE_W-1:0];
        carry_d                = slice_sum[SLICE_W];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          ovf_d   = msb_cin ^ slice_sum[SLICE_W];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result selection and flags; everything reads zero outside DONE.
  always_comb begin
    is_done  = (state_q == DONE);
    slt_bit  = sum_q[WIDTH-1] ^ ovf_q;
    sltu_bit = ~carry_q;
    case (op_q)
      OP_SLT:  final_result = WIDTH'(slt_bit);
      OP_SLTU: final_result = WIDTH'(sltu_bit);
      default: final_result = sum_q;
    endcase

    o_valid    = is_done;
    o_ready    = (state_q == IDLE);
    o_busy     = (state_q != IDLE);
    o_result   = is_done ? final_result : '0;
    o_carry    = is_done & carry_q;
    o_overflow = is_done & ovf_q;
    o_zero     = is_done & (final_result == '0);
    o_negative = is_done & final_result[WIDTH-1];
  end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench for addsub_multicycle: WIDTH=32/SLICE_W=8 main instance,
// plus 16/16 and 64/4 instances for the parameter sweep.
module tb_addsub_multicycle;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] SLT  = 2'b10;
  localparam logic [1:0] SLTU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32/8 instance
  logic        vin32, rdy32, vout32, ir32, c32, vf32, z32, n32, busy32;
  logic [31:0] a32, b32, res32;
  logic [1:0]  op32;
  // 16/16 instance
  logic        vin16, rdy16, vout16, ir16, c16, vf16, z16, n16, busy16;
  logic [15:0] a16, b16, res16;
  logic [1:0]  op16;
  // 64/4 instance
  logic        vin64, rdy64, vout64, ir64, c64, vf64, z64, n64, busy64;
  logic [63:0] a64, b64, res64;
  logic [1:0]  op64;

  exp_t q32[$];
  exp_t q16[$];
  exp_t q64[$];
  int   acc32 = 0, acc16 = 0, acc64 = 0;
  logic prev32 = 1'b0, prev16 = 1'b0, prev64 = 1'b0;

  addsub_multicycle #(.WIDTH(32), .SLICE_W(8)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_valid(vin32), .o_ready(rdy32),
    .i_a(a32), .i_b(b32), .i_op(op32), .o_valid(vout32), .i_ready(ir32),
    .o_result(res32), .o_carry(c32), .o_overflow(vf32), .o_zero(z32),
    .o_negative(n32), .o_busy(busy32)
  );

  addsub_multicycle #(.WIDTH(16), .SLICE_W(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_valid(vin16), .o_ready(rdy16),
    .i_a(a16), .i_b(b16), .i_op(op16), .o_valid(vout16), .i_ready(ir16),
    .o_result(res16), .o_carry(c16), .o_overflow(vf16), .o_zero(z16),
    .o_negative(n16), .o_busy(busy16)
  );

  addsub_multicycle #(.WIDTH(64), .SLICE_W(4)) dut64 (
    .i_clk(clk), .i_reset(rst), .i_valid(vin64), .o_ready(rdy64),
    .i_a(a64), .i_b(b64), .i_op(op64), .o_valid(vout64), .i_ready(ir64),
    .o_result(res64), .o_carry(c64), .o_overflow(vf64), .o_zero(z64),
    .o_negative(n64), .o_busy(busy64)
  );

  function automatic exp_t mk(input logic [63:0] r, input logic c, input logic v,
                              input logic z, input logic n);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.v   = v;
    e.z   = z;
    e.n   = n;
    return e;
  endfunction

  // Single-cycle reference: A + (B or ~B) + sub_like over the low w bits.
  function automatic exp_t ref_model(input int w, input logic [63:0] a_in,
                                     input logic [63:0] b_in, input logic [1:0] op);
    logic [63:0] mask, a, bb, r, fin;
    logic [64:0] s;
    logic        c, v, sub;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sub  = (op != ADD);
    a    = a_in & mask;
    bb   = (sub ? ~b_in : b_in) & mask;
    s    = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
    c    = s[w];
    r    = s[63:0] & mask;
    v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    case (op)
      SLT:     fin = {63'd0, r[w-1] ^ v};
      SLTU:    fin = {63'd0, ~c};
      default: fin = r;
    endcase
    return mk(fin, c, v, (fin == 64'd0), fin[w-1]);
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got res=%0h c=%0b v=%0b z=%0b n=%0b, expected res=%0h c=%0b v=%0b z=%0b n=%0b",
               name, act.res, act.c, act.v, act.z, act.n, exp.res, exp.c, exp.v, exp.z, exp.n);
    end
  endtask

  // Monitor for the 32-bit instance: compares every valid cycle against the
  // queue head (so held outputs are checked too) and pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev32 = 1'b0;
    end else begin
      if (vout32 && !prev32) checkValue("latency32", 64'(cyc - acc32), 64'd4);
      if (vout32) begin
        if (q32.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL out32: unexpected output res=%0h, expected none", res32);
        end else begin
          checkOutput("out32", mk({32'd0, res32}, c32, vf32, z32, n32), q32[0]);
          if (ir32) void'(q32.pop_front());
        end
      end
      if (vin32 && rdy32) acc32 = cyc + 1;
      prev32 = vout32;
    end
  end

  // Monitor for the 16-bit single-slice instance.
  always @(negedge clk) begin
    if (rst) begin
      prev16 = 1'b0;
    end else begin
      if (vout16 && !prev16) checkValue("latency16", 64'(cyc - acc16), 64'd1);
      if (vout16) begin
        if (q16.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL out16: unexpected output res=%0h, expected none", res16);
        end else begin
          checkOutput("out16", mk({48'd0, res16}, c16, vf16, z16, n16), q16[0]);
          if (ir16) void'(q16.pop_front());
        end
      end
      if (vin16 && rdy16) acc16 = cyc + 1;
      prev16 = vout16;
    end
  end

  // Monitor for the 64-bit, 16-slice instance.
  always @(negedge clk) begin
    if (rst) begin
      prev64 = 1'b0;
    end else begin
      if (vout64 && !prev64) checkValue("latency64", 64'(cyc - acc64), 64'd16);
      if (vout64) begin
        if (q64.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL out64: unexpected output res=%0h, expected none", res64);
        end else begin
          checkOutput("out64", mk(res64, c64, vf64, z64, n64), q64[0]);
          if (ir64) void'(q64.pop_front());
        end
      end
      if (vin64 && rdy64) acc64 = cyc + 1;
      prev64 = vout64;
    end
  end

  // Issue one request to the 32-bit instance and queue its expected response.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               input exp_t e, output int waited);
    int n = 0;
    a32 = a; b32 = b; op32 = op; vin32 = 1'b1;
    while (!rdy32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy32) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept32: ready=%0b after %0d cycles, expected 1", rdy32, n);
    end else begin
      q32.push_back(e);
    end
    @(posedge clk); #1;
    vin32  = 1'b0;
    waited = n;
  endtask

  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                                 input exp_t e);
    int n = 0;
    a16 = a; b16 = b; op16 = op; vin16 = 1'b1;
    while (!rdy16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy16) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept16: ready=%0b after %0d cycles, expected 1", rdy16, n);
    end else begin
      q16.push_back(e);
    end
    @(posedge clk); #1;
    vin16 = 1'b0;
  endtask

  task automatic applyStimulus64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                                 input exp_t e);
    int n = 0;
    a64 = a; b64 = b; op64 = op; vin64 = 1'b1;
    while (!rdy64 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy64) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept64: ready=%0b after %0d cycles, expected 1", rdy64, n);
    end else begin
      q64.push_back(e);
    end
    @(posedge clk); #1;
    vin64 = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_ready"}, 64'(rdy32), 64'd1);
    checkValue({tag, "_valid"}, 64'(vout32), 64'd0);
    checkValue({tag, "_busy"}, 64'(busy32), 64'd0);
    checkValue({tag, "_result"}, 64'(res32), 64'd0);
    checkValue({tag, "_flags"}, 64'({c32, vf32, z32, n32}), 64'd0);
  endtask

  task automatic waitValid32();
    int n = 0;
    while (!vout32 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vout32) begin
      checks++;
      fails++;
      $display("[TB] FAIL wait_valid32: valid=%0b after %0d cycles, expected 1", vout32, n);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || q64.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (q32.size() != 0 || q16.size() != 0 || q64.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: pending %0d/%0d/%0d responses, expected 0",
               q32.size(), q16.size(), q64.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    logic [63:0] ra, rb;
    logic [1:0]  rop;

    rst = 1'b1;
    vin32 = 0; a32 = 0; b32 = 0; op32 = 0; ir32 = 1;
    vin16 = 0; a16 = 0; b16 = 0; op16 = 0; ir16 = 1;
    vin64 = 0; a64 = 0; b64 = 0; op64 = 0; ir64 = 1;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset_init");
    rst = 1'b0;
    @(posedge clk); #1;

    // Add / sub / compare vectors
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, ADD,  mk(64'h0, 1, 0, 1, 0), w);
    applyStimulus(32'h8000_0000, 32'h0000_0001, SUB,  mk(64'h7FFF_FFFF, 1, 1, 0, 0), w);
    applyStimulus(32'h0000_0005, 32'h0000_0007, SUB,  mk(64'hFFFF_FFFE, 0, 0, 0, 1), w);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, SLT,  mk(64'h1, 1, 0, 0, 0), w);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, SLTU, mk(64'h0, 1, 0, 1, 0), w);
    applyStimulus(32'h1234_5678, 32'h1234_5678, SLT,  mk(64'h0, 1, 0, 1, 0), w);
    waitDrain();

    // Backpressure, ignored requests while busy, back-to-back accept
    ir32 = 1'b0;
    applyStimulus(32'h0000_0003, 32'h7FFF_FFFF, ADD, mk(64'h8000_0002, 0, 1, 0, 1), w);
    checkValue("busy_calc", 64'(busy32), 64'd1);
    checkValue("ready_calc", 64'(rdy32), 64'd0);
    a32 = 32'h1; b32 = 32'h1; op32 = ADD; vin32 = 1'b1;
    @(posedge clk); #1;
    vin32 = 1'b0;
    waitValid32();
    vin32 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkValue("ready_done", 64'(rdy32), 64'd0);
    vin32 = 1'b0;
    ir32  = 1'b1;
    @(posedge clk); #1;
    checkValue("ready_after_ack", 64'(rdy32), 64'd1);
    checkValue("valid_after_ack", 64'(vout32), 64'd0);
    applyStimulus(32'h0000_0001, 32'h0000_0002, SLTU, mk(64'h1, 0, 0, 0, 0), w);
    checkValue("b2b_wait", 64'(w), 64'd0);
    waitDrain();

    // Reset in the middle of CALC, then the same request again
    applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, ADD, mk(64'h1010_1010, 0, 0, 0, 0), w);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q32.delete();
    #1;
    checkResetState("reset_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, ADD, mk(64'h1010_1010, 0, 0, 0, 0), w);
    waitDrain();

    // Single-slice 16-bit instance
    applyStimulus16(16'h0000, 16'h0001, SUB, mk(64'hFFFF, 0, 0, 0, 1));
    applyStimulus16(16'h7FFF, 16'h0001, ADD, mk(64'h8000, 0, 1, 0, 1));
    waitDrain();

    // 64-bit, 4-bit slices: one hand vector, then random against the reference
    applyStimulus64(64'h8000_0000_0000_0000, 64'h1, SLT, mk(64'h1, 1, 1, 0, 0));
    for (int i = 0; i < 10; i++) begin
      ra  = {$urandom, $urandom};
      rb  = (i == 3) ? ra : {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      applyStimulus64(ra, rb, rop, ref_model(64, ra, rb, rop));
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
